// File: rtl/ctl_req_master.sv
// Initiator for the 134-bit two-word control-packet chain: serialises one read/write command,
// waits for the read response on the chain tail, and counts stray response packets.
module ctl_req_master #(
  parameter logic [7:0]  SRC_MID        = 8'd1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [7:0]       cmd_dst_mid,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [31:0]      rsp_rdata,
  output logic             busy,
  output logic [133:0]     cout_data,
  output logic             cout_data_wr,
  input  logic             cin_ready,
  input  logic [133:0]     rin_data,
  input  logic             rin_data_wr,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend1,
    StSend2,
    StWaitResp,
    StDrain
  } state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [7:0]         dst_q, dst_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [133:0]       cout_data_q, cout_data_d;
  logic               cout_wr_q, cout_wr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               rin_first;
  logic               rin_second;
  logic               rin_match;
  logic               match_taken;
  logic [133:0]       req_word1;

  assign rin_first  = rin_data_wr && (rin_data[133:132] == 2'b01);
  assign rin_second = rin_data_wr && (rin_data[133:132] == 2'b10);
  assign rin_match  = rin_first && (rin_data[127:124] == 4'b1011) &&
                      (rin_data[103:96] == SRC_MID) && (rin_data[95:64] == addr_q);

  // Opcode nibble is {1'b0, 3'b010} for writes and {1'b0, 3'b001} for reads.
  assign req_word1 = {2'b01, 4'h0, 1'b0, (op_q ? 3'b010 : 3'b001), 12'h0, SRC_MID, dst_q,
                      addr_q, 32'h0, (op_q ? wdata_q : 32'h0)};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    timer_d     = timer_q;
    cout_data_d = cout_data_q;
    cout_wr_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    match_taken = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst_mid;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = StSend1;
        end
      end
      StSend1: begin
        if (cin_ready) begin
          cout_data_d = req_word1;
          cout_wr_d   = 1'b1;
          state_d     = StSend2;
        end
      end
      StSend2: begin
        // cin_ready guaranteed room for both words, so word 2 never stalls.
        cout_data_d = {2'b10, 132'h0};
        cout_wr_d   = 1'b1;
        if (op_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          state_d     = StIdle;
        end else begin
          timer_d = '0;
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        timer_d = timer_q + 1'b1;
        if (rin_match) begin
          match_taken = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rin_data[31:0];
          state_d     = StDrain;
        end else if (timer_q == TimerLast) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'hFFFF_FFFF;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        if (rin_second) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Every first word not consumed as our response is a drop, whatever the state.
  always_comb begin
    drop_d = drop_q;
    if (rin_first && !match_taken && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      dst_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timer_q     <= '0;
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timer_q     <= timer_d;
      cout_data_q <= cout_data_d;
      cout_wr_q   <= cout_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      drop_q      <= drop_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign cout_data    = cout_data_q;
  assign cout_data_wr = cout_wr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_ctl_req_master.sv
// Directed bench for ctl_req_master: writes, reads, backpressure, timeout, drops, saturation, reset.
module tb_ctl_req_master;

  localparam int unsigned Tmo = 20;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [7:0]   cmd_dst_mid;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         rsp_valid;
  logic         rsp_err;
  logic [31:0]  rsp_rdata;
  logic         busy;
  logic [133:0] cout_data;
  logic         cout_data_wr;
  logic         cin_ready;
  logic [133:0] rin_data;
  logic         rin_data_wr;
  logic [1:0]   drop_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  ctl_req_master #(
    .SRC_MID        (8'd1),
    .TIMEOUT_CYCLES (Tmo),
    .CNT_W          (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dst_mid  (cmd_dst_mid),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .cout_data    (cout_data),
    .cout_data_wr (cout_data_wr),
    .cin_ready    (cin_ready),
    .rin_data     (rin_data),
    .rin_data_wr  (rin_data_wr),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [133:0] Word2 = {2'b10, 132'h0};

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] rsp_w1(input logic [31:0] addr, input logic [31:0] data);
    return {2'b01, 4'h0, 4'b1011, 12'h0, 8'h05, 8'd1, addr, 32'h0, data};
  endfunction

  task automatic issue(input logic op, input logic [7:0] dst, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_dst_mid = dst;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    step();
    cmd_valid   = 1'b0;
  endtask

  // Read with cin_ready high: checks both request words and leaves the DUT in WAIT_RESP.
  task automatic read_send(input string tag, input logic [31:0] addr);
    issue(1'b0, 8'd3, addr, 32'hDEAD_BEEF);
    step();
    chk({tag, "_w1"}, cout_data, {2'b01, 4'h0, 4'b0001, 12'h0, 8'd1, 8'd3, addr, 64'h0});
    step();
    chk({tag, "_w2"}, cout_data, Word2);
  endtask

  task automatic rin_put(input logic [133:0] w);
    rin_data    = w;
    rin_data_wr = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_dst_mid = '0; cmd_addr = '0;
    cmd_wdata = '0; cin_ready = 1'b1; rin_data = '0; rin_data_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cout", {cout_data_wr, cout_data}, 0);
    chk("rst_drop", drop_cnt, 0);

    // 1: write, no response wait
    issue(1'b1, 8'd7, 32'h7000_0003, 32'h11);
    chk("wr_ready_low", cmd_ready, 0);
    chk("wr_busy", busy, 1);
    step();
    chk("wr_w1", {cout_data_wr, cout_data},
        {1'b1, 2'b01, 4'h0, 4'b0010, 12'h0, 8'd1, 8'd7, 32'h7000_0003, 32'h0, 32'h11});
    step();
    chk("wr_w2", {cout_data_wr, cout_data}, {1'b1, Word2});
    chk("wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
    step();
    chk("wr_after", {cout_data_wr, rsp_valid, cmd_ready}, 3'b001);
    chk("wr_hold", cout_data, Word2);

    // 2: read, response 5 cycles after word 2
    read_send("rd", 32'h7000_0008);
    repeat (4) step();
    chk("rd_wait", {rsp_valid, busy, cout_data_wr}, 3'b010);
    rin_put(rsp_w1(32'h7000_0008, 32'h1234));
    step();
    chk("rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h1234});
    rin_put(Word2);
    chk("rd_drain_busy", cmd_ready, 0);
    step();
    rin_data_wr = 1'b0;
    chk("rd_idle", {cmd_ready, rsp_valid, rsp_rdata}, {2'b10, 32'h1234});
    chk("rd_drop", drop_cnt, 0);

    // 3: backpressure, then all-ones data that is not an error
    cin_ready = 1'b0;
    issue(1'b0, 8'd3, 32'h7000_000C, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_no_wr", cout_data_wr, 0);
    end
    cin_ready = 1'b1;
    step();
    chk("bp_w1", {cout_data_wr, cout_data},
        {1'b1, 2'b01, 4'h0, 4'b0001, 12'h0, 8'd1, 8'd3, 32'h7000_000C, 64'h0});
    step();
    chk("bp_w2", {cout_data_wr, cout_data}, {1'b1, Word2});
    rin_put(rsp_w1(32'h7000_000C, 32'hFFFF_FFFF));
    step();
    chk("bp_ones", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hFFFF_FFFF});
    rin_put(Word2);
    step();
    rin_data_wr = 1'b0;
    chk("bp_idle", cmd_ready, 1);

    // 4: timeout exactly Tmo cycles after entering WAIT_RESP, then late response dropped
    read_send("tmo", 32'h7000_0020);
    for (int i = 1; i < Tmo; i++) step();
    chk("tmo_early", rsp_valid, 0);
    step();
    chk("tmo_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'hFFFF_FFFF});
    chk("tmo_idle", cmd_ready, 1);
    rin_put(rsp_w1(32'h7000_0020, 32'h55));
    step();
    chk("tmo_drop1", drop_cnt, 1);
    chk("tmo_no_rsp", rsp_valid, 0);
    rin_put(Word2);
    step();
    rin_data_wr = 1'b0;
    chk("tmo_w2_uncounted", drop_cnt, 1);

    // 5: wrong address dropped, correct one taken
    read_send("wa", 32'h7000_0010);
    rin_put(rsp_w1(32'h7000_0014, 32'hBAD));
    step();
    rin_put(Word2);
    step();
    rin_data_wr = 1'b0;
    chk("wa_drop2", {drop_cnt, rsp_valid}, {2'd2, 1'b0});
    step();
    rin_put(rsp_w1(32'h7000_0010, 32'hCAFE));
    step();
    chk("wa_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hCAFE});
    rin_put(Word2);
    step();
    rin_data_wr = 1'b0;
    chk("wa_idle_drop", {cmd_ready, drop_cnt}, {1'b1, 2'd2});

    // match on the timeout cycle wins
    read_send("mt", 32'h7000_0030);
    for (int i = 1; i < Tmo; i++) step();
    rin_put(rsp_w1(32'h7000_0030, 32'h77));
    step();
    chk("mt_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h77});
    rin_put(Word2);
    step();
    rin_data_wr = 1'b0;
    chk("mt_idle", {cmd_ready, drop_cnt}, {1'b1, 2'd2});

    // drop counter saturation with stray first words in IDLE
    rin_put(rsp_w1(32'h1, 32'h1));
    step();
    chk("sat_3", drop_cnt, 3);
    step();
    rin_data_wr = 1'b0;
    chk("sat_hold", drop_cnt, 3);

    // 6: asynchronous reset in WAIT_RESP
    read_send("ar", 32'h7000_0040);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out", {busy, cout_data_wr, rsp_valid, cout_data}, 0);
    chk("ar_ready", cmd_ready, 1);
    chk("ar_drop", drop_cnt, 0);
    #3 rst_n = 1'b1;
    step();
    chk("ar_release", {cmd_ready, busy, drop_cnt}, {2'b10, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
